cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - 9-bit program sequencer driving an accumulator datapath
//
// Purpose: holds a small program store that is loaded word by word while the
// block is idle or halted, then executes one instruction per cycle in RUN.
// Arithmetic and load-immediate instructions issue a one-cycle registered
// strobe to an external accumulator datapath.
//
// Optional feature: define CPU_SEQ_LOOP_EN to enable the SETC/DJNZ loop
// counter; without it opcodes 101/110 execute as NOP and no counter exists.
//
// Ports:
//   CLK          rising-edge clock
//   RESET_N      asynchronous active-low reset
//   LOAD_VALID   program word offered
//   LOAD_DATA    program word (opcode[8:6], operand[5:0])
//   LOAD_READY   program store accepts words (IDLE/HALT)
//   START        begin execution at address 0
//   INSTRUCTION  operand to the datapath for ADD/SUB
//   write_en     datapath write strobe
//   is_add       1 = add, 0 = subtract
//   is_immediate select imm_val in the datapath
//   imm_val      immediate value for LDI
//   pc           current program address
//   busy         high in RUN
//   halted       high in HALT
module cpu_sequencer #(
    parameter int PROG_DEPTH = 8,
    parameter int AW         = 3
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          LOAD_VALID,
    input  logic [8:0]    LOAD_DATA,
    output logic          LOAD_READY,
    input  logic          START,
    output logic [8:0]    INSTRUCTION,
    output logic          write_en,
    output logic          is_add,
    output logic          is_immediate,
    output logic [7:0]    imm_val,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_LDI  = 3'b011;
    localparam logic [2:0] OP_JMP  = 3'b100;
    localparam logic [2:0] OP_DJNZ = 3'b101;
    localparam logic [2:0] OP_SETC = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] load_ptr_q, load_ptr_d;
    logic [8:0]    instr_q, instr_d;
    logic          we_q, we_d;
    logic          add_q, add_d;
    logic          imm_sel_q, imm_sel_d;
    logic [7:0]    imm_q, imm_d;
    logic          mem_we;
`ifdef CPU_SEQ_LOOP_EN
    logic [5:0]    cnt_q, cnt_d;
`endif

    // Program store is deliberately outside the reset domain so a program
    // survives reset and can be rerun with START.
    logic [8:0]    mem_q [PROG_DEPTH];

    logic [8:0]    word;
    logic [2:0]    opcode;
    logic [5:0]    op;

    assign word   = mem_q[pc_q];
    assign opcode = word[8:6];
    assign op     = word[5:0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        load_ptr_d = load_ptr_q;
        mem_we     = 1'b0;
        instr_d    = '0;
        we_d       = 1'b0;
        add_d      = 1'b0;
        imm_sel_d  = 1'b0;
        imm_d      = '0;
`ifdef CPU_SEQ_LOOP_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            S_IDLE, S_HALT: begin
                // A load in the same cycle as START takes priority.
                if (LOAD_VALID) begin
                    mem_we     = 1'b1;
                    load_ptr_d = load_ptr_q + AW'(1);
                end else if (START) begin
                    state_d    = S_RUN;
                    pc_d       = '0;
                    load_ptr_d = '0;
                end
            end
            S_RUN: begin
                pc_d = pc_q + AW'(1);
                case (opcode)
                    OP_ADD: begin
                        we_d    = 1'b1;
                        add_d   = 1'b1;
                        instr_d = {3'b000, op};
                    end
                    OP_SUB: begin
                        we_d    = 1'b1;
                        instr_d = {3'b000, op};
                    end
                    OP_LDI: begin
                        we_d      = 1'b1;
                        imm_sel_d = 1'b1;
                        imm_d     = {2'b00, op};
                    end
                    OP_JMP: pc_d = op[AW-1:0];
`ifdef CPU_SEQ_LOOP_EN
                    OP_SETC: cnt_d = op;
                    OP_DJNZ: begin
                        // Branch test uses the count before decrement, so
                        // SETC n yields n+1 passes through the loop body.
                        cnt_d = cnt_q - 6'd1;
                        if (cnt_q != 6'd0) begin
                            pc_d = op[AW-1:0];
                        end
                    end
`endif
                    OP_HALT: begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            load_ptr_q <= '0;
            instr_q    <= '0;
            we_q       <= 1'b0;
            add_q      <= 1'b0;
            imm_sel_q  <= 1'b0;
            imm_q      <= '0;
`ifdef CPU_SEQ_LOOP_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            load_ptr_q <= load_ptr_d;
            instr_q    <= instr_d;
            we_q       <= we_d;
            add_q      <= add_d;
            imm_sel_q  <= imm_sel_d;
            imm_q      <= imm_d;
`ifdef CPU_SEQ_LOOP_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[load_ptr_q] <= LOAD_DATA;
        end
    end

    assign LOAD_READY   = (state_q != S_RUN);
    assign busy         = (state_q == S_RUN);
    assign halted       = (state_q == S_HALT);
    assign pc           = pc_q;
    assign INSTRUCTION  = instr_q;
    assign write_en     = we_q;
    assign is_add       = add_q;
    assign is_immediate = imm_sel_q;
    assign imm_val      = imm_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       LOAD_VALID;
    logic [8:0] LOAD_DATA;
    logic       LOAD_READY;
    logic       START;
    logic [8:0] INSTRUCTION;
    logic       write_en;
    logic       is_add;
    logic       is_immediate;
    logic [7:0] imm_val;
    logic [2:0] pc;
    logic       busy;
    logic       halted;

    int n_checks = 0;
    int n_errors = 0;
    int strobes;
    int exp_strobes;

    cpu_sequencer #(.PROG_DEPTH(8), .AW(3)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .LOAD_VALID   (LOAD_VALID),
        .LOAD_DATA    (LOAD_DATA),
        .LOAD_READY   (LOAD_READY),
        .START        (START),
        .INSTRUCTION  (INSTRUCTION),
        .write_en     (write_en),
        .is_add       (is_add),
        .is_immediate (is_immediate),
        .imm_val      (imm_val),
        .pc           (pc),
        .busy         (busy),
        .halted       (halted)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [8:0] w);
        LOAD_VALID = 1'b1;
        LOAD_DATA  = w;
        @(negedge CLK);
        LOAD_VALID = 1'b0;
        LOAD_DATA  = '0;
    endtask

    task automatic start_run();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    initial begin
        RESET_N    = 1'b0;
        LOAD_VALID = 1'b0;
        LOAD_DATA  = '0;
        START      = 1'b0;
        repeat (2) @(negedge CLK);

        // Reset state
        check("rst_load_ready", 32'(LOAD_READY), 32'd1);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_halted",     32'(halted),     32'd0);
        check("rst_pc",         32'(pc),         32'd0);
        check("rst_write_en",   32'(write_en),   32'd0);
        check("rst_instr",      32'(INSTRUCTION), 32'd0);
        check("rst_imm",        32'(imm_val),    32'd0);
        RESET_N = 1'b1;
        @(negedge CLK);

        // ADD 5, SUB 2, HALT
        load_word(9'h045);
        load_word(9'h082);
        load_word(9'h1C0);
        start_run();
        check("b_busy",       32'(busy),       32'd1);
        check("b_ready_run",  32'(LOAD_READY), 32'd0);
        check("b_pc0",        32'(pc),         32'd0);
        check("b_we_idle",    32'(write_en),   32'd0);
        @(negedge CLK);
        check("b_add_we",     32'(write_en),   32'd1);
        check("b_add_instr",  32'(INSTRUCTION), 32'd5);
        check("b_add_isadd",  32'(is_add),     32'd1);
        check("b_add_pc",     32'(pc),         32'd1);
        @(negedge CLK);
        check("b_sub_we",     32'(write_en),   32'd1);
        check("b_sub_instr",  32'(INSTRUCTION), 32'd2);
        check("b_sub_isadd",  32'(is_add),     32'd0);
        check("b_sub_pc",     32'(pc),         32'd2);
        @(negedge CLK);
        check("b_halt_we",    32'(write_en),   32'd0);
        check("b_halted",     32'(halted),     32'd1);
        check("b_halt_busy",  32'(busy),       32'd0);
        check("b_halt_pc",    32'(pc),         32'd2);
        check("b_halt_ready", 32'(LOAD_READY), 32'd1);

        // LDI 0x3F, HALT
        load_word(9'h0FF);
        load_word(9'h1C0);
        start_run();
        check("c_halted_clr", 32'(halted),     32'd0);
        check("c_busy",       32'(busy),       32'd1);
        @(negedge CLK);
        check("c_we",         32'(write_en),   32'd1);
        check("c_isimm",      32'(is_immediate), 32'd1);
        check("c_imm",        32'(imm_val),    32'h3F);
        check("c_instr",      32'(INSTRUCTION), 32'd0);
        @(negedge CLK);
        check("c_we_off",     32'(write_en),   32'd0);
        check("c_isimm_off",  32'(is_immediate), 32'd0);
        check("c_imm_off",    32'(imm_val),    32'd0);
        check("c_halted",     32'(halted),     32'd1);
        check("c_pc",         32'(pc),         32'd1);

        // SETC 3, ADD 1, DJNZ 1, HALT
`ifdef CPU_SEQ_LOOP_EN
        exp_strobes = 4;
`else
        exp_strobes = 1;
`endif
        load_word(9'h183);
        load_word(9'h041);
        load_word(9'h141);
        load_word(9'h1C0);
        start_run();
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (write_en) begin
                strobes++;
                check("d_strobe_instr", 32'(INSTRUCTION), 32'd1);
            end
            if (halted) break;
        end
        check("d_strobes", 32'(strobes), 32'(exp_strobes));
        check("d_halted",  32'(halted),  32'd1);
        check("d_pc",      32'(pc),      32'd3);

        // JMP 0 followed by NOPs: pc stays at 0
        load_word(9'h100);
        for (int i = 0; i < 7; i++) load_word(9'h000);
        start_run();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("e_pc_stay", 32'(pc),   32'd0);
            check("e_busy",    32'(busy), 32'd1);
        end
        #2 RESET_N = 1'b0;
        #1;
        check("e_rst_busy",  32'(busy),       32'd0);
        check("e_rst_ready", 32'(LOAD_READY), 32'd1);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Eight NOPs: pc wraps 7 -> 0
        for (int i = 0; i < 8; i++) load_word(9'h000);
        start_run();
        repeat (7) @(negedge CLK);
        check("f_pc7",    32'(pc),   32'd7);
        @(negedge CLK);
        check("f_pc_wrap", 32'(pc),  32'd0);
        check("f_busy",   32'(busy), 32'd1);
        #2 RESET_N = 1'b0;
        #1;
        check("f_rst_busy", 32'(busy), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // START together with LOAD_VALID: load wins, stays IDLE
        LOAD_VALID = 1'b1;
        LOAD_DATA  = 9'h0EA;
        START      = 1'b1;
        @(negedge CLK);
        LOAD_VALID = 1'b0;
        LOAD_DATA  = '0;
        START      = 1'b0;
        check("g_busy",  32'(busy),       32'd0);
        check("g_ready", 32'(LOAD_READY), 32'd1);
        load_word(9'h1C0);
        start_run();
        @(negedge CLK);
        check("g_we",     32'(write_en),     32'd1);
        check("g_isimm",  32'(is_immediate), 32'd1);
        check("g_imm",    32'(imm_val),      32'h2A);
        @(negedge CLK);
        check("g_halted", 32'(halted), 32'd1);
        check("g_pc",     32'(pc),     32'd1);

        // ADD 5 / JMP 0 loop, load attempt in RUN, async reset mid-strobe
        load_word(9'h045);
        load_word(9'h100);
        start_run();
        @(negedge CLK);
        check("h_we1",    32'(write_en),    32'd1);
        check("h_instr1", 32'(INSTRUCTION), 32'd5);
        LOAD_VALID = 1'b1;
        LOAD_DATA  = 9'h1C0;
        check("h_ready_run", 32'(LOAD_READY), 32'd0);
        @(negedge CLK);
        LOAD_VALID = 1'b0;
        LOAD_DATA  = '0;
        check("h_jmp_we", 32'(write_en), 32'd0);
        check("h_jmp_pc", 32'(pc),       32'd0);
        @(negedge CLK);
        check("h_we2",    32'(write_en), 32'd1);
        #2 RESET_N = 1'b0;
        #1;
        check("h_rst_we",     32'(write_en),    32'd0);
        check("h_rst_instr",  32'(INSTRUCTION), 32'd0);
        check("h_rst_isadd",  32'(is_add),      32'd0);
        check("h_rst_busy",   32'(busy),        32'd0);
        check("h_rst_pc",     32'(pc),          32'd0);
        check("h_rst_ready",  32'(LOAD_READY),  32'd1);
        @(negedge CLK);
        RESET_N = 1'b1;
        start_run();
        @(negedge CLK);
        check("h_rerun_we",    32'(write_en),    32'd1);
        check("h_rerun_instr", 32'(INSTRUCTION), 32'd5);
        check("h_rerun_isadd", 32'(is_add),      32'd1);
        @(negedge CLK);
        check("h_rerun_jmp",   32'(pc),          32'd0);
        check("h_rerun_halt",  32'(halted),      32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
